n64adv_osd_wr_sched: RTL and testbench

//  Write scheduler for the OSD text/colour RAM write port (25-bit OSD write vector {wrctrl,wraddr,wrdata}).

---
 rtl/n64adv_osd_wr_sched_pkg.sv | 8 +
 rtl/n64adv_osd_wr_sched_fifo.sv | 43 ++++
 rtl/n64adv_osd_wr_sched.sv | 86 ++++++++
 tb/tb_n64adv_osd_wr_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/n64adv_osd_wr_sched_pkg.sv
// n64adv_osd_wr_sched_pkg: shared types and constants for the OSD write scheduler
package n64adv_osd_wr_sched_pkg;
  localparam int OSD_WRCTRL_TXT = 0;
  localparam int OSD_WRCTRL_COL = 1;
  localparam logic [1:0] WRCTRL_NONE = 2'b00;
  localparam logic [1:0] WRCTRL_BOTH = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_CDONE} state_e;
endpackage

// File: rtl/n64adv_osd_wr_sched_fifo.sv
// n64adv_osd_wr_sched_fifo: CPU write-request FIFO with flush; flush+push leaves only the new entry
module n64adv_osd_wr_sched_fifo #(
  parameter int AW = 2,
  parameter int W  = 25
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [W-1:0]  mem_q [2**AW];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   lvl_q;
  logic          do_pop, do_push, we;
  logic [AW-1:0] wa;
  assign full_o  = lvl_q[AW];
  assign empty_o = lvl_q == '0;
  assign dout_o  = mem_q[rd_q];
  assign level_o = lvl_q;
  assign do_pop  = pop_i && !empty_o;
  // a pop frees the slot a same-cycle push needs when full
  assign do_push = push_i && (!full_o || do_pop);
  assign we      = flush_i ? push_i : do_push;
  assign wa      = flush_i ? '0 : wr_q;
  always_ff @(posedge clk_i)
    if (we) mem_q[wa] <= din_i;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      lvl_q <= '0;
    end else begin
      rd_q  <= flush_i ? '0 : rd_q + AW'(do_pop);
      wr_q  <= flush_i ? AW'(push_i) : wr_q + AW'(do_push);
      lvl_q <= flush_i ? (AW+1)'(push_i) : lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/n64adv_osd_wr_sched.sv
// n64adv_osd_wr_sched: schedules queued CPU writes and a bulk clear onto the OSD RAM write port
module n64adv_osd_wr_sched
  import n64adv_osd_wr_sched_pkg::*;
#(
  parameter int                FIFO_AW  = 2,
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 13,
  parameter logic [DATA_W-1:0] CLR_DATA = '0,
  parameter logic [ADDR_W-1:0] CLR_LAST = '1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       cpu_req_i,
  input  logic [1:0]                 cpu_wrctrl_i,
  input  logic [ADDR_W-1:0]          cpu_wraddr_i,
  input  logic [DATA_W-1:0]          cpu_wrdata_i,
  input  logic                       clr_req_i,
  input  logic                       wr_window_i,
  input  logic                       ovf_clr_i,
  output logic [2+ADDR_W+DATA_W-1:0] osd_wrvec_o,
  output logic                       clr_busy_o,
  output logic                       clr_done_o,
  output logic [FIFO_AW:0]           fifo_lvl_o,
  output logic                       ovf_o
);
  localparam int VW = 2 + ADDR_W + DATA_W;
  state_e            state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [VW-1:0]     vec_q, head, idle_vec;
  logic              busy_q, done_q, ovf_q;
  logic              push, pop, full, empty, drop;
  assign push = cpu_req_i && |cpu_wrctrl_i;
  assign pop  = state_q == ST_IDLE && wr_window_i && !clr_req_i;
  // a full FIFO only accepts when the head leaves in the same cycle
  assign drop = push && full && !pop && !clr_req_i;
  assign idle_vec = {WRCTRL_NONE, vec_q[VW-3:0]};
  n64adv_osd_wr_sched_fifo #(.AW(FIFO_AW), .W(VW)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (clr_req_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({cpu_wrctrl_i, cpu_wraddr_i, cpu_wrdata_i}),
    .dout_o  (head),
    .level_o (fifo_lvl_o),
    .full_o  (full),
    .empty_o (empty)
  );
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      clr_addr_q <= '0;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= drop | (ovf_q & ~ovf_clr_i);
      if (clr_req_i) begin
        state_q    <= ST_CLEAR;
        clr_addr_q <= '0;
        busy_q     <= 1'b1;
        vec_q      <= idle_vec;
      end else
        case (state_q)
          ST_IDLE: vec_q <= (pop && !empty) ? head : idle_vec;
          ST_CLEAR: begin
            vec_q <= wr_window_i ? {WRCTRL_BOTH, clr_addr_q, CLR_DATA} : idle_vec;
            if (wr_window_i && clr_addr_q == CLR_LAST) state_q <= ST_CDONE;
            else if (wr_window_i) clr_addr_q <= clr_addr_q + ADDR_W'(1);
          end
          ST_CDONE: begin
            vec_q   <= idle_vec;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
    end
  assign osd_wrvec_o = vec_q;
  assign clr_busy_o  = busy_q;
  assign clr_done_o  = done_q;
  assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_n64adv_osd_wr_sched.sv
// tb_n64adv_osd_wr_sched: directed and randomized checks against a queue-based reference model
module tb_n64adv_osd_wr_sched;
  logic        clk = 0, rst_n = 0;
  logic        req = 0, clr = 0, win = 0, oclr = 0;
  logic [1:0]  ctrl = 0;
  logic [9:0]  addr = 0;
  logic [12:0] data = 0;
  logic [24:0] osd_wrvec;
  logic        clr_busy, clr_done, ovf;
  logic [2:0]  fifo_lvl;
  int checks = 0, errors = 0;
  logic [24:0] m_q[$];
  logic [24:0] m_vec;
  bit          m_clearing, m_cdone, m_busy, m_done, m_ovf;
  int          m_next;

  n64adv_osd_wr_sched dut (
    .clk_i(clk), .rst_n_i(rst_n), .cpu_req_i(req), .cpu_wrctrl_i(ctrl),
    .cpu_wraddr_i(addr), .cpu_wrdata_i(data), .clr_req_i(clr), .wr_window_i(win),
    .ovf_clr_i(oclr), .osd_wrvec_o(osd_wrvec), .clr_busy_o(clr_busy),
    .clr_done_o(clr_done), .fifo_lvl_o(fifo_lvl), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_q.delete();
    m_vec = '0; m_clearing = 0; m_cdone = 0; m_busy = 0; m_done = 0; m_ovf = 0; m_next = 0;
  endfunction

  // one clock of the scheduler's rules, phrased as queue operations
  function automatic void model_update();
    logic [24:0] e = {ctrl, addr, data};
    bit p = req && ctrl != 2'b00;
    bit set = 0;
    m_done = 0;
    m_vec[24:23] = 2'b00;
    if (clr) begin
      m_q.delete();
      if (p) m_q.push_back(e);
      m_clearing = 1; m_cdone = 0; m_next = 0; m_busy = 1;
    end else begin
      if (m_clearing) begin
        if (win) begin
          m_vec = {2'b11, 10'(m_next), 13'h0};
          if (m_next == 1023) begin m_clearing = 0; m_cdone = 1; end
          else m_next++;
        end
      end else if (m_cdone) begin
        m_done = 1; m_busy = 0; m_cdone = 0;
      end else if (win && m_q.size() > 0) m_vec = m_q.pop_front();
      if (p) begin
        if (m_q.size() < 4) m_q.push_back(e);
        else set = 1;
      end
    end
    m_ovf = set ? 1'b1 : oclr ? 1'b0 : m_ovf;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; req = 0; clr = 0; win = 0; oclr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (osd_wrvec !== 25'h0) begin errors++; $display("FAIL reset_vec: got %h want 0", osd_wrvec); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", clr_busy); end
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", clr_done); end
    checks++; if (fifo_lvl !== 3'd0) begin errors++; $display("FAIL reset_lvl: got %0d want 0", fifo_lvl); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_latency();
    logic [24:0] exp = {2'b01, 10'h005, 13'h0041};
    win = 1; req = 1; ctrl = 2'b01; addr = 10'h005; data = 13'h0041;
    tick();
    req = 0;
    tick();
    checks++; if (osd_wrvec !== exp) begin errors++; $display("FAIL lat_issue: got %h want %h", osd_wrvec, exp); end
    tick();
    checks++; if (osd_wrvec[24:23] !== 2'b00) begin errors++; $display("FAIL lat_idle: got %b want 00", osd_wrvec[24:23]); end
  endtask

  task automatic test_overflow();
    logic [24:0] e[5];
    win = 0;
    for (int i = 0; i < 5; i++) begin
      e[i] = {2'(i % 3 + 1), 10'($urandom), 13'($urandom)};
      {ctrl, addr, data} = e[i];
      req = 1;
      tick();
    end
    req = 0;
    checks++; if (fifo_lvl !== 3'd4) begin errors++; $display("FAIL ovf_lvl: got %0d want 4", fifo_lvl); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf); end
    win = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (osd_wrvec !== e[i]) begin errors++; $display("FAIL ovf_order%0d: got %h want %h", i, osd_wrvec, e[i]); end
    end
    tick();
    checks++; if (osd_wrvec[24:23] !== 2'b00) begin errors++; $display("FAIL ovf_fifth: got %h want wrctrl 00", osd_wrvec); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    oclr = 1;
    tick();
    oclr = 0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf); end
  endtask

  task automatic test_clear();
    int bad = 0;
    win = 1; clr = 1;
    tick();
    clr = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      if (osd_wrvec !== {2'b11, 10'(i), 13'h0} || clr_busy !== 1'b1 || clr_done !== 1'b0) begin
        if (bad < 4) $display("FAIL clr_write%0d: got %h busy %b want %h busy 1", i, osd_wrvec, clr_busy, {2'b11, 10'(i), 13'h0});
        bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL clr_sweep: got %0d bad cycles want 0", bad); end
    tick();
    checks++; if (clr_done !== 1'b1 || clr_busy !== 1'b0) begin errors++; $display("FAIL clr_done: got done %b busy %b want 1 0", clr_done, clr_busy); end
    tick();
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL clr_done_pulse: got %b want 0", clr_done); end
  endtask

  task automatic test_window_toggle();
    int nxt = 0, cyc = 0, bad = 0;
    bit done = 0;
    win = 1; clr = 1;
    tick();
    clr = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      win = (k % 2 == 0);
      tick();
      cyc = k + 1;
      if ({osd_wrvec, clr_busy, clr_done, fifo_lvl, ovf} !== {m_vec, m_busy, m_done, 3'(m_q.size()), m_ovf}) bad++;
      if (osd_wrvec[24:23] == 2'b11) begin
        if (osd_wrvec[22:13] !== 10'(nxt) || !win) bad++;
        nxt++;
      end
      done = clr_done;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL tog_seq: got %0d bad cycles want 0", bad); end
    checks++; if (nxt != 1024) begin errors++; $display("FAIL tog_count: got %0d writes want 1024", nxt); end
    checks++; if (cyc != 2048 || !done) begin errors++; $display("FAIL tog_cycles: got %0d done %b want 2048", cyc, done); end
  endtask

  task automatic test_flush_post();
    logic [24:0] ent = {2'b10, 10'h2AB, 13'h1234};
    bit armed = 0, done = 0;
    win = 0;
    for (int i = 0; i < 3; i++) begin
      {ctrl, addr, data} = {2'b01, 10'(i + 7), 13'(i)};
      req = 1;
      tick();
    end
    req = 0;
    checks++; if (fifo_lvl !== 3'd3) begin errors++; $display("FAIL fl_pre: got %0d want 3", fifo_lvl); end
    clr = 1; win = 1;
    tick();
    clr = 0;
    checks++; if (fifo_lvl !== 3'd0 || clr_busy !== 1'b1) begin errors++; $display("FAIL fl_flush: got lvl %0d busy %b want 0 1", fifo_lvl, clr_busy); end
    for (int k = 0; k < 1100 && !done; k++) begin
      tick();
      req = 0;
      if (osd_wrvec === {2'b11, 10'h200, 13'h0} && !armed) begin
        {ctrl, addr, data} = ent;
        req = 1; armed = 1;
      end
      done = clr_done;
    end
    checks++; if (!done || fifo_lvl !== 3'd1) begin errors++; $display("FAIL fl_done: got done %b lvl %0d want 1 1", done, fifo_lvl); end
    tick();
    checks++; if (osd_wrvec !== ent) begin errors++; $display("FAIL fl_post: got %h want %h", osd_wrvec, ent); end
  endtask

  task automatic test_restart_reset();
    bit hit = 0;
    win = 1; clr = 1;
    tick();
    clr = 0;
    for (int k = 0; k < 400 && !hit; k++) begin
      tick();
      hit = osd_wrvec === {2'b11, 10'h100, 13'h0};
    end
    checks++; if (!hit) begin errors++; $display("FAIL rs_reach: got no write at 100 want one"); end
    clr = 1;
    tick();
    clr = 0;
    tick();
    checks++; if (osd_wrvec !== {2'b11, 10'h000, 13'h0}) begin errors++; $display("FAIL rs_restart: got %h want %h", osd_wrvec, {2'b11, 10'h000, 13'h0}); end
    hit = 0;
    for (int k = 0; k < 400 && !hit; k++) begin
      tick();
      hit = osd_wrvec === {2'b11, 10'h080, 13'h0};
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++; if ({osd_wrvec, clr_busy, clr_done, fifo_lvl, ovf} !== 31'h0 || !hit) begin
      errors++; $display("FAIL rs_async: got vec %h busy %b lvl %0d reached %b want all 0", osd_wrvec, clr_busy, fifo_lvl, hit);
    end
    @(negedge clk) rst_n = 1;
    tick();
    checks++; if (osd_wrvec !== 25'h0 || clr_busy !== 1'b0) begin errors++; $display("FAIL rs_after: got %h busy %b want 0 0", osd_wrvec, clr_busy); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int k = 0; k < 4000; k++) begin
      win  = ($urandom % 4) != 0;
      req  = ($urandom % 3) == 0;
      ctrl = 2'($urandom);
      addr = 10'($urandom);
      data = 13'($urandom);
      oclr = ($urandom % 50) == 0;
      clr  = ($urandom % 1500) == 0 || k == 100;
      if (k == 100) begin req = 1; ctrl = 2'b01; end
      tick();
      if ({osd_wrvec, clr_busy, clr_done, fifo_lvl, ovf} !== {m_vec, m_busy, m_done, 3'(m_q.size()), m_ovf}) begin
        if (bad < 4) $display("FAIL rnd_cyc%0d: got %h %b %b %0d %b want %h %b %b %0d %b", k,
          osd_wrvec, clr_busy, clr_done, fifo_lvl, ovf, m_vec, m_busy, m_done, m_q.size(), m_ovf);
        bad++;
      end
    end
    req = 0; clr = 0; oclr = 0;
    checks++; if (bad != 0) begin errors++; $display("FAIL rnd_total: got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overflow();
    test_clear();
    test_window_toggle();
    test_flush_post();
    test_restart_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
